// File: rtl/riscv_pipe_pkg.sv
// riscv_pipe_pkg: shared widths and enums for the ID/EX operand stage
package riscv_pipe_pkg;
  localparam int XLEN = 32;
  localparam int REG_AW = 5;
  localparam int CTRL_W = 16;
  typedef enum logic [1:0] {FWD_RF, FWD_EXMEM, FWD_WB, FWD_ZERO} fwd_sel_t;
  typedef enum logic {RUN, BUBBLE} stage_state_t;
endpackage

// File: rtl/operand_fwd_mux.sv
// operand_fwd_mux: resolves one source operand, priority x0 > EX/MEM > WB > regfile
// The WB path exists only when BYPASS_WB_EN is defined.
module operand_fwd_mux
  import riscv_pipe_pkg::*;
(
  input  logic [REG_AW-1:0] rs,
  input  logic [XLEN-1:0]   rf_data,
  input  logic              exmem_wr,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [XLEN-1:0]   exmem_data,
  input  logic              wb_wr,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic [XLEN-1:0]   operand,
  output fwd_sel_t          fwd_sel
);
  logic wb_hit;
`ifdef BYPASS_WB_EN
  assign wb_hit = wb_wr && wb_rd == rs;
`else
  logic unused_wb;
  assign unused_wb = ^{wb_wr, wb_rd, wb_data};
  assign wb_hit = 1'b0;
`endif
  assign fwd_sel = rs == '0 ? FWD_ZERO :
                   exmem_wr && exmem_rd == rs ? FWD_EXMEM :
                   wb_hit ? FWD_WB : FWD_RF;
  always_comb begin
    operand = rf_data;
    if (fwd_sel == FWD_ZERO) operand = '0;
    else if (fwd_sel == FWD_EXMEM) operand = exmem_data;
`ifdef BYPASS_WB_EN
    else if (fwd_sel == FWD_WB) operand = wb_data;
`endif
  end
endmodule

// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage: operand resolution, load-use/flush handling and ID/EX payload register
// BYPASS_WB_EN enables WB forwarding; without it a WB write to a used source costs one bubble.
module id_ex_operand_stage
  import riscv_pipe_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              id_mem_read,
  output logic              id_stall,
  output logic [REG_AW-1:0] rf_addr1,
  output logic [REG_AW-1:0] rf_addr2,
  input  logic [XLEN-1:0]   rf_data1,
  input  logic [XLEN-1:0]   rf_data2,
  input  logic              exmem_wr,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [XLEN-1:0]   exmem_data,
  input  logic              wb_wr,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              ex_ready,
  input  logic              flush,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_rs1_val,
  output logic [XLEN-1:0]   ex_rs2_val,
  output logic [XLEN-1:0]   ex_imm,
  output logic [REG_AW-1:0] ex_rd,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              ex_mem_read
);
  stage_state_t state;
  logic flush_pend, kill, luh, wbh, hazard, take;
  logic [XLEN-1:0] op1, op2;
  fwd_sel_t sel1, sel2;
  assign rf_addr1 = id_rs1;
  assign rf_addr2 = id_rs2;
  operand_fwd_mux u_fwd1 (.rs(id_rs1), .rf_data(rf_data1), .exmem_wr(exmem_wr), .exmem_rd(exmem_rd),
    .exmem_data(exmem_data), .wb_wr(wb_wr), .wb_rd(wb_rd), .wb_data(wb_data), .operand(op1), .fwd_sel(sel1));
  operand_fwd_mux u_fwd2 (.rs(id_rs2), .rf_data(rf_data2), .exmem_wr(exmem_wr), .exmem_rd(exmem_rd),
    .exmem_data(exmem_data), .wb_wr(wb_wr), .wb_rd(wb_rd), .wb_data(wb_data), .operand(op2), .fwd_sel(sel2));
  assign luh = id_valid & ex_valid & ex_mem_read & (ex_rd != '0) &
               ((id_use_rs1 & ex_rd == id_rs1) | (id_use_rs2 & ex_rd == id_rs2));
`ifdef BYPASS_WB_EN
  logic unused_sel;
  assign unused_sel = ^{sel1, sel2};
  assign wbh = 1'b0;
`else
  // FWD_RF means rs!=0 with no EX/MEM match, so the regfile write is still in flight
  assign wbh = id_valid & wb_wr & (wb_rd != '0) &
               ((id_use_rs1 & wb_rd == id_rs1 & sel1 == FWD_RF) |
                (id_use_rs2 & wb_rd == id_rs2 & sel2 == FWD_RF));
`endif
  assign kill = flush | flush_pend;
  assign hazard = (luh | wbh) & (state == RUN) & ~kill;
  assign id_stall = ~ex_ready | hazard;
  assign take = id_valid & ~kill & ~hazard;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      flush_pend <= 1'b0;
      ex_valid <= 1'b0;
      ex_pc <= '0;
      ex_rs1_val <= '0;
      ex_rs2_val <= '0;
      ex_imm <= '0;
      ex_rd <= '0;
      ex_ctrl <= '0;
      ex_mem_read <= 1'b0;
    end else if (!ex_ready) begin
      flush_pend <= flush_pend | flush;
    end else begin
      state <= hazard ? BUBBLE : RUN;
      flush_pend <= 1'b0;
      ex_valid <= take;
      ex_pc <= take ? id_pc : '0;
      ex_rs1_val <= take ? op1 : '0;
      ex_rs2_val <= take ? op2 : '0;
      ex_imm <= take ? id_imm : '0;
      ex_rd <= take ? id_rd : '0;
      ex_ctrl <= take ? id_ctrl : '0;
      ex_mem_read <= take & id_mem_read;
    end
  end
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb_id_ex_operand_stage: forwarding vector table plus hazard/flush/reset sequences, scoreboard-checked
module tb_id_ex_operand_stage;
  import riscv_pipe_pkg::*;
`ifdef BYPASS_WB_EN
  localparam bit WBF = 1'b1;
`else
  localparam bit WBF = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic id_valid, id_use_rs1, id_use_rs2, id_mem_read, exmem_wr, wb_wr, ex_ready, flush;
  logic [XLEN-1:0] id_pc, id_imm, rf_data1, rf_data2, exmem_data, wb_data;
  logic [REG_AW-1:0] id_rs1, id_rs2, id_rd, exmem_rd, wb_rd;
  logic [CTRL_W-1:0] id_ctrl;
  logic id_stall, ex_valid, ex_mem_read;
  logic [REG_AW-1:0] rf_addr1, rf_addr2, ex_rd;
  logic [XLEN-1:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
  logic [CTRL_W-1:0] ex_ctrl;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;

  id_ex_operand_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_imm(id_imm), .id_ctrl(id_ctrl),
    .id_mem_read(id_mem_read), .id_stall(id_stall), .rf_addr1(rf_addr1), .rf_addr2(rf_addr2),
    .rf_data1(rf_data1), .rf_data2(rf_data2), .exmem_wr(exmem_wr), .exmem_rd(exmem_rd),
    .exmem_data(exmem_data), .wb_wr(wb_wr), .wb_rd(wb_rd), .wb_data(wb_data), .ex_ready(ex_ready),
    .flush(flush), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val),
    .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl), .ex_mem_read(ex_mem_read)
  );

  typedef struct packed {
    logic valid, mem_read;
    logic [XLEN-1:0] pc, rs1_val, rs2_val, imm;
    logic [REG_AW-1:0] rd;
    logic [CTRL_W-1:0] ctrl;
  } exp_t;
  typedef struct packed {
    logic [REG_AW-1:0] rs1, rs2;
    logic [XLEN-1:0] rf1, rf2;
    logic ew;
    logic [REG_AW-1:0] erd;
    logic [XLEN-1:0] edata;
    logic ww;
    logic [REG_AW-1:0] wrd;
    logic [XLEN-1:0] wdata, e1, e2;
  } vec_t;
  exp_t sb[$];
  exp_t held;
  vec_t tbl[7];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t bub();
    exp_t e;
    e = '0;
    return e;
  endfunction

  function automatic exp_t cur(logic [XLEN-1:0] r1, logic [XLEN-1:0] r2);
    exp_t e;
    e.valid = 1'b1;
    e.mem_read = id_mem_read;
    e.pc = id_pc;
    e.imm = id_imm;
    e.rd = id_rd;
    e.ctrl = id_ctrl;
    e.rs1_val = r1;
    e.rs2_val = r2;
    return e;
  endfunction

  task automatic pop_cmp(string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty", tag);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_valid"}, 32'(ex_valid), 32'(e.valid));
    chk({tag, "_mem_read"}, 32'(ex_mem_read), 32'(e.mem_read));
    chk({tag, "_pc"}, ex_pc, e.pc);
    chk({tag, "_rs1_val"}, ex_rs1_val, e.rs1_val);
    chk({tag, "_rs2_val"}, ex_rs2_val, e.rs2_val);
    chk({tag, "_imm"}, ex_imm, e.imm);
    chk({tag, "_rd"}, 32'(ex_rd), 32'(e.rd));
    chk({tag, "_ctrl"}, 32'(ex_ctrl), 32'(e.ctrl));
  endtask

  task automatic cyc(string tag, logic stall, exp_t e);
    #1;
    chk({tag, "_stall"}, 32'(id_stall), 32'(stall));
    sb.push_back(e);
    @(posedge clk);
    #1;
    pop_cmp(tag);
  endtask

  task automatic instr(logic [XLEN-1:0] pc, logic [REG_AW-1:0] rs1, logic [REG_AW-1:0] rs2, logic u1, logic u2,
                       logic [REG_AW-1:0] rd, logic mr, logic [XLEN-1:0] imm, logic [CTRL_W-1:0] ctrl);
    id_valid = 1'b1;
    id_pc = pc;
    id_rs1 = rs1;
    id_rs2 = rs2;
    id_use_rs1 = u1;
    id_use_rs2 = u2;
    id_rd = rd;
    id_mem_read = mr;
    id_imm = imm;
    id_ctrl = ctrl;
  endtask

  task automatic clr_fwd();
    exmem_wr = 1'b0;
    exmem_rd = '0;
    exmem_data = '0;
    wb_wr = 1'b0;
    wb_rd = '0;
    wb_data = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    instr(0, 0, 0, 0, 0, 0, 0, 0, 0);
    id_valid = 1'b0;
    rf_data1 = '0;
    rf_data2 = '0;
    ex_ready = 1'b1;
    flush = 1'b0;
    clr_fwd();
    tbl[0] = '{5'd5, 5'd6, 32'hA, 32'hB, 1'b1, 5'd5, 32'hDEAD, 1'b1, 5'd5, 32'h1111, 32'hDEAD, 32'hB};
    tbl[1] = '{5'd0, 5'd6, 32'hA, 32'hB, 1'b1, 5'd5, 32'hDEAD, 1'b1, 5'd5, 32'h1111, 32'h0, 32'hB};
    tbl[2] = '{5'd3, 5'd4, 32'h10, 32'h20, 1'b1, 5'd4, 32'h44, 1'b1, 5'd3, 32'h33, WBF ? 32'h33 : 32'h10, 32'h44};
    tbl[3] = '{5'd3, 5'd4, 32'h10, 32'h20, 1'b0, 5'd3, 32'h55, 1'b0, 5'd4, 32'h66, 32'h10, 32'h20};
    tbl[4] = '{5'd0, 5'd0, 32'h10, 32'h20, 1'b1, 5'd0, 32'h99, 1'b1, 5'd0, 32'h88, 32'h0, 32'h0};
    tbl[5] = '{5'd31, 5'd31, 32'h1, 32'h2, 1'b1, 5'd31, 32'hFFFFFFFF, 1'b0, 5'd0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    tbl[6] = '{5'd7, 5'd7, 32'h5, 32'h6, 1'b1, 5'd8, 32'hBAD, 1'b1, 5'd7, 32'h77, WBF ? 32'h77 : 32'h5, WBF ? 32'h77 : 32'h6};
    #12;
    chk("rst_valid", 32'(ex_valid), 32'd0);
    chk("rst_pc", ex_pc, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    // operand selection vectors; use flags off so no hazard can interfere
    for (int i = 0; i < 7; i++) begin
      instr(32'h1000 + 32'(4 * i), tbl[i].rs1, tbl[i].rs2, 1'b0, 1'b0, 5'(i + 1), 1'b0, 32'(3 * i), 16'hA500 + 16'(i));
      rf_data1 = tbl[i].rf1;
      rf_data2 = tbl[i].rf2;
      exmem_wr = tbl[i].ew;
      exmem_rd = tbl[i].erd;
      exmem_data = tbl[i].edata;
      wb_wr = tbl[i].ww;
      wb_rd = tbl[i].wrd;
      wb_data = tbl[i].wdata;
      #1;
      chk($sformatf("vec%0d_rf_addr1", i), 32'(rf_addr1), 32'(tbl[i].rs1));
      chk($sformatf("vec%0d_rf_addr2", i), 32'(rf_addr2), 32'(tbl[i].rs2));
      cyc($sformatf("vec%0d", i), 1'b0, cur(tbl[i].e1, tbl[i].e2));
    end
    clr_fwd();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(ex_valid), 32'd0);
    chk("mid_rst_pc", ex_pc, 32'd0);
    chk("mid_rst_rs1", ex_rs1_val, 32'd0);
    chk("mid_rst_ctrl", 32'(ex_ctrl), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    instr(32'h1800, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, 32'h8, 16'h0101);
    rf_data1 = 32'h11;
    rf_data2 = 32'h22;
    cyc("post_rst", 1'b0, cur(32'h11, 32'h22));
    // load-use: lw x7 then add x8,x7,x2
    instr(32'h2000, 5'd1, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 32'h4, 16'h0011);
    rf_data1 = 32'h100;
    rf_data2 = 32'h0;
    cyc("lw", 1'b0, cur(32'h100, 32'h0));
    instr(32'h2004, 5'd7, 5'd2, 1'b1, 1'b1, 5'd8, 1'b0, 32'h0, 16'h0022);
    rf_data1 = 32'h7777;
    rf_data2 = 32'h22;
    cyc("lu_stall", 1'b1, bub());
    exmem_wr = 1'b1;
    exmem_rd = 5'd7;
    exmem_data = 32'h42;
    cyc("lu_fwd", 1'b0, cur(32'h42, 32'h22));
    clr_fwd();
    // WB write and ID read of the same register in one cycle
    instr(32'h3000, 5'd0, 5'd3, 1'b0, 1'b1, 5'd4, 1'b0, 32'h0, 16'h0033);
    rf_data1 = 32'h0;
    rf_data2 = 32'd9;
    wb_wr = 1'b1;
    wb_rd = 5'd3;
    wb_data = 32'd77;
`ifdef BYPASS_WB_EN
    cyc("wb_byp", 1'b0, cur(32'h0, 32'd77));
`else
    cyc("wb_stall", 1'b1, bub());
    rf_data2 = 32'd77;
    cyc("wb_rf", 1'b0, cur(32'h0, 32'd77));
`endif
    clr_fwd();
    // back-pressure with a flush in the first held cycle
    instr(32'h4000, 5'd1, 5'd2, 1'b1, 1'b1, 5'd9, 1'b0, 32'h8, 16'h0044);
    rf_data1 = 32'h11;
    rf_data2 = 32'h22;
    held = cur(32'h11, 32'h22);
    cyc("bp_a", 1'b0, held);
    instr(32'h4004, 5'd1, 5'd2, 1'b1, 1'b1, 5'd10, 1'b0, 32'h0, 16'h0055);
    ex_ready = 1'b0;
    flush = 1'b1;
    cyc("bp_h1", 1'b1, held);
    flush = 1'b0;
    cyc("bp_h2", 1'b1, held);
    cyc("bp_h3", 1'b1, held);
    ex_ready = 1'b1;
    cyc("bp_bub", 1'b0, bub());
    instr(32'h4008, 5'd1, 5'd2, 1'b1, 1'b1, 5'd11, 1'b0, 32'hC, 16'h0066);
    cyc("bp_b", 1'b0, cur(32'h11, 32'h22));
    // flush coinciding with a load-use hazard
    instr(32'h5000, 5'd1, 5'd2, 1'b1, 1'b0, 5'd9, 1'b1, 32'h0, 16'h0077);
    cyc("fl_lw", 1'b0, cur(32'h11, 32'h22));
    instr(32'h5004, 5'd9, 5'd2, 1'b1, 1'b1, 5'd10, 1'b0, 32'h0, 16'h0088);
    flush = 1'b1;
    cyc("fl_kill", 1'b0, bub());
    flush = 1'b0;
    instr(32'h5008, 5'd9, 5'd2, 1'b1, 1'b1, 5'd11, 1'b0, 32'h0, 16'h0099);
    cyc("fl_next", 1'b0, cur(32'h11, 32'h22));
    instr(32'h500C, 5'd1, 5'd2, 1'b1, 1'b0, 5'd12, 1'b1, 32'h0, 16'h00AA);
    cyc("fl_lw2", 1'b0, cur(32'h11, 32'h22));
    instr(32'h5010, 5'd12, 5'd2, 1'b1, 1'b1, 5'd13, 1'b0, 32'h0, 16'h00BB);
    cyc("fl_lu", 1'b1, bub());
    exmem_wr = 1'b1;
    exmem_rd = 5'd12;
    exmem_data = 32'h99;
    cyc("fl_lu_fwd", 1'b0, cur(32'h99, 32'h22));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
